g4_prbs_os_sequencer: RTL and testbench

- Controls both lanes' Gen4 PRBS11 ordered-set transmitters during link training.
- Arms the generators, keeps them enabled until a programmed number of ordered sets has been sent, then shuts them off.
- Checks that lane 0 and lane 1 stay aligned at OS boundaries, and watches for a stalled generator.
- Sits between the training-state logic and the per-lane PRBS11 senders. Their enable is level-sensitive: low means reload seed.

---
 rtl/g4_prbs_os_sequencer.sv | 161 ++++++++++++++++
 tb/tb_g4_prbs_os_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/g4_prbs_os_sequencer.sv
// Gen4 PRBS11 ordered-set sequencer: arms both lane senders, counts OS boundaries to a target, flags skew/stall.
// Optional macro G4_LANE_SKEW_CHECK_EN: require lane 1 to pulse with lane 0 (mismatch gives err_code 01).
//
// state | meaning
// IDLE  | waiting for start
// ARM   | one cycle with prbs_en low so both senders reload their seeds
// SEND  | senders enabled, counting ordered sets, watching gap and skew
// DONE  | one-cycle completion pulse
// ERR   | skew or stall detected, held until err_clr

module g4_prbs_os_sequencer #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             err_clr,
  input  logic [CNT_W-1:0] os_target,
  input  logic             os_sent_l0,
  input  logic             os_sent_l1,
  output logic             prbs_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] os_count
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_SEND = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             prbs_en_q, prbs_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_inc;
  logic             os_both;
  logic             os_skew;

`ifdef G4_LANE_SKEW_CHECK_EN
  assign os_both = os_sent_l0 & os_sent_l1;
  assign os_skew = os_sent_l0 ^ os_sent_l1;
`else
  // Lane 1 is not consulted in this build; the port is kept so instances match.
  logic unused_l1;
  assign unused_l1 = os_sent_l1;
  assign os_both   = os_sent_l0;
  assign os_skew   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    count_d    = count_q;
    gap_d      = gap_q;
    err_code_d = err_code_q;
    count_inc  = count_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d = os_target;
          count_d  = '0;
          gap_d    = '0;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        state_d = (target_q == '0) ? S_DONE : S_SEND;
      end
      S_SEND: begin
        if (os_skew) begin
          gap_d      = '0;
          err_code_d = 2'b01;
          state_d    = S_ERR;
        end else if (os_both) begin
          gap_d   = '0;
          count_d = count_inc;
          if (count_inc == target_q) state_d = S_DONE;
        end else if (gap_q == GAP_LAST) begin
          err_code_d = 2'b10;
          state_d    = S_ERR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) begin
          err_code_d = 2'b00;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over completion and error detection, and leaves the count where it was.
    if (abort && (state_q == S_ARM || state_q == S_SEND || state_q == S_DONE)) begin
      state_d    = S_IDLE;
      count_d    = count_q;
      gap_d      = gap_q;
      err_code_d = err_code_q;
    end

    prbs_en_d = (state_d == S_SEND);
    busy_d    = (state_d == S_ARM) || (state_d == S_SEND);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      err_code_q <= 2'b00;
      prbs_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      err_code_q <= err_code_d;
      prbs_en_q  <= prbs_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign prbs_en  = prbs_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign os_count = count_q;

endmodule

// File: tb/tb_g4_prbs_os_sequencer.sv
// Bench for g4_prbs_os_sequencer: directed runs; done/err events are checked by a scoreboard monitor.
// Skew expectations follow G4_LANE_SKEW_CHECK_EN.

module tb_g4_prbs_os_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] os_target = 8'd0;
  logic       os_sent_l0 = 1'b0;
  logic       os_sent_l1 = 1'b0;
  logic       prbs_en, busy, done, err;
  logic [1:0] err_code;
  logic [7:0] os_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic err_prev = 1'b0;

  g4_prbs_os_sequencer #(.CNT_W(8), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .err_clr(err_clr),
    .os_target(os_target), .os_sent_l0(os_sent_l0), .os_sent_l1(os_sent_l1),
    .prbs_en(prbs_en), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .os_count(os_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic os_pulse(input logic l0, input logic l1);
    os_sent_l0 = l0;
    os_sent_l1 = l1;
    cycle(1);
    os_sent_l0 = 1'b0;
    os_sent_l1 = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] tgt);
    os_target = tgt;
    start = 1'b1;
    cycle(1);
    start = 1'b0;
  endtask

  task automatic expect_event(input logic is_err, input logic [1:0] code, input logic [7:0] cnt);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.cnt    = cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: every done pulse or rising err must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (done || (err && !err_prev))) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: done=%0d err=%0d code=%0d count=%0d, expected no event at %0t",
                 done, err, err_code, os_count, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_kind_err", int'(err), int'(mon_e.is_err));
        check("sb_code", int'(err_code), int'(mon_e.code));
        check("sb_count", int'(os_count), int'(mon_e.cnt));
      end
    end
    err_prev = err;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected under 1ms", $time);
    $fatal(1);
  end

  initial begin
    cycle(2);
    check("rst_prbs_en", prbs_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_os_count", os_count, 0);
    reset = 1'b0;
    cycle(2);

    // Normal run, target 3, both lanes pulsing every 448 cycles.
    start_run(8'd3);
    check("norm_arm_busy", busy, 1);
    check("norm_arm_prbs_en", prbs_en, 0);
    cycle(1);
    check("norm_send_prbs_en", prbs_en, 1);
    for (int i = 1; i <= 3; i++) begin
      cycle(447);
      if (i == 3) expect_event(1'b0, 2'b00, 8'd3);
      os_pulse(1'b1, 1'b1);
      check("norm_os_count", os_count, i);
      if (i < 3) check("norm_prbs_en_mid", prbs_en, 1);
    end
    check("norm_done", done, 1);
    check("norm_prbs_en_done", prbs_en, 0);
    cycle(1);
    check("norm_done_single", done, 0);
    check("norm_prbs_en_after", prbs_en, 0);
    check("norm_busy_after", busy, 0);
    check("norm_count_held", os_count, 3);
    os_pulse(1'b1, 1'b1);
    check("idle_pulse_ignored", os_count, 3);

    // Zero target: ARM then DONE, prbs_en never high.
    start_run(8'd0);
    check("zero_arm_prbs_en", prbs_en, 0);
    check("zero_arm_busy", busy, 1);
    expect_event(1'b0, 2'b00, 8'd0);
    cycle(1);
    check("zero_done", done, 1);
    check("zero_prbs_en", prbs_en, 0);
    check("zero_count", os_count, 0);
    cycle(1);
    check("zero_idle_busy", busy, 0);

    // Only lane 0 pulses at the first boundary.
    start_run(8'd5);
    cycle(1);
    cycle(10);
`ifdef G4_LANE_SKEW_CHECK_EN
    expect_event(1'b1, 2'b01, 8'd0);
    os_pulse(1'b1, 1'b0);
    check("skew_err", err, 1);
    check("skew_code", err_code, 1);
    check("skew_prbs_en", prbs_en, 0);
    check("skew_count", os_count, 0);
    start = 1'b1;
    cycle(1);
    start = 1'b0;
    check("skew_start_ignored", err, 1);
    err_clr = 1'b1;
    cycle(1);
    err_clr = 1'b0;
    check("skew_clr_err", err, 0);
    check("skew_clr_code", err_code, 0);
    check("skew_clr_busy", busy, 0);
`else
    os_pulse(1'b1, 1'b0);
    check("noskew_err", err, 0);
    check("noskew_count", os_count, 1);
    check("noskew_prbs_en", prbs_en, 1);
    abort = 1'b1;
    cycle(1);
    abort = 1'b0;
    check("noskew_abort_busy", busy, 0);
`endif
    cycle(2);

    // Timeout with no pulses: err exactly 1024 cycles after prbs_en rises.
    start_run(8'd2);
    cycle(1);
    check("to_prbs_en", prbs_en, 1);
    expect_event(1'b1, 2'b10, 8'd0);
    cycle(1023);
    check("to_not_yet", err, 0);
    check("to_prbs_en_1023", prbs_en, 1);
    cycle(1);
    check("to_err", err, 1);
    check("to_code", err_code, 2);
    check("to_prbs_en_off", prbs_en, 0);
    abort = 1'b1;
    cycle(1);
    abort = 1'b0;
    check("to_abort_ignored", err, 1);
    err_clr = 1'b1;
    cycle(1);
    err_clr = 1'b0;
    check("to_clr_err", err, 0);
    check("to_clr_code", err_code, 0);

    // Abort after the 4th OS; a mid-run start with target 3 must not be latched.
    start_run(8'd10);
    cycle(1);
    for (int i = 1; i <= 4; i++) begin
      cycle(20);
      os_pulse(1'b1, 1'b1);
      if (i == 2) begin
        os_target = 8'd3;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
      end
    end
    check("abort_pre_count", os_count, 4);
    check("abort_pre_busy", busy, 1);
    cycle(3);
    abort = 1'b1;
    cycle(1);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_prbs_en", prbs_en, 0);
    check("abort_done", done, 0);
    check("abort_count", os_count, 4);
    cycle(2);
    start_run(8'd1);
    cycle(1);
    cycle(5);
    expect_event(1'b0, 2'b00, 8'd1);
    os_pulse(1'b1, 1'b1);
    check("restart_done", done, 1);
    check("restart_count", os_count, 1);
    cycle(2);

    // Asynchronous reset mid-SEND, between clock edges.
    start_run(8'd4);
    cycle(1);
    cycle(5);
    os_pulse(1'b1, 1'b1);
    check("arst_pre_count", os_count, 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_prbs_en", prbs_en, 0);
    check("arst_busy", busy, 0);
    check("arst_count", os_count, 0);
    cycle(2);
    reset = 1'b0;
    cycle(2);

    check("sb_pending", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
